// File: rtl/game_pkg.sv
// Shared map definitions for the tile renderer, map RAM and player controller.
package game_pkg;

    localparam int MAP_W  = 20;
    localparam int MAP_H  = 15;
    localparam int COL_W  = 5;
    localparam int ROW_W  = 4;
    localparam int TILE_W = 3;

    typedef enum logic [TILE_W-1:0] {
        TILE_ROAD   = 3'b000,
        TILE_GRASS  = 3'b001,
        TILE_PLAYER = 3'b010
    } tile_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WR_OLD  = 3'd2,
        ST_WR_NEW  = 3'd3,
        ST_RESPAWN = 3'd4
    } state_e;

endpackage

// File: rtl/switch_debounce.sv
// Synchronizes and debounces one raw switch; pulses o_Rise when the debounced level goes high.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles. No backpressure.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= i_Switch;
            sync_q <= meta_q;
            rise_q <= 1'b0;
            // Any cycle agreeing with the current level restarts the stability count.
            if (sync_q != level_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync_q;
                    rise_q  <= sync_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign o_Rise = rise_q;

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement: debounced switch edges -> read target tile, restore old cell, stamp new cell.
// Latency: 4 busy cycles per move with ready high; edges while busy are dropped. WRAP_X_EN enables horizontal wrap.
module player_move_ctrl
    import game_pkg::*;
#(
    parameter int GRID_W          = MAP_W,
    parameter int GRID_H          = MAP_H,
    parameter int START_X         = 10,
    parameter int START_Y         = 14,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Switch_1,
    input  logic              i_Switch_2,
    input  logic              i_Switch_3,
    input  logic              i_Switch_4,
    output logic [ROW_W-1:0]  o_Rd_Row,
    output logic [COL_W-1:0]  o_Rd_Col,
    input  logic [TILE_W-1:0] i_Rd_Tile,
    output logic              o_Wr_Valid,
    output logic [ROW_W-1:0]  o_Wr_Row,
    output logic [COL_W-1:0]  o_Wr_Col,
    output logic [TILE_W-1:0] o_Wr_Tile,
    input  logic              i_Wr_Ready,
    output logic [COL_W-1:0]  o_Player_X,
    output logic [ROW_W-1:0]  o_Player_Y,
    output logic              o_Busy,
    output logic              o_Level_Up
);

    logic up_e, dn_e, lf_e, rt_e;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_Switch(i_Switch_1), .o_Rise(up_e));
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_Switch(i_Switch_2), .o_Rise(dn_e));
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lf (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_Switch(i_Switch_3), .o_Rise(lf_e));
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rt (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_Switch(i_Switch_4), .o_Rise(rt_e));

    state_e              state_q;
    logic                rd_wait_q;
    logic [COL_W-1:0]    player_x_q, tx_q, rd_col_q, wr_col_q;
    logic [ROW_W-1:0]    player_y_q, ty_q, rd_row_q, wr_row_q;
    logic [TILE_W-1:0]   under_q, new_under_q, wr_tile_q;
    logic                wr_valid_q, busy_q, level_q;

    logic                mv_ok_d;
    logic [COL_W-1:0]    mv_x_d;
    logic [ROW_W-1:0]    mv_y_d;

    // Priority up > down > left > right; lower-priority edges in the same cycle are lost.
    always_comb begin
        mv_ok_d = 1'b0;
        mv_x_d  = player_x_q;
        mv_y_d  = player_y_q;
        if (up_e) begin
            mv_ok_d = (player_y_q != '0);
            mv_y_d  = player_y_q - 1'b1;
        end else if (dn_e) begin
            mv_ok_d = (player_y_q != ROW_W'(GRID_H - 1));
            mv_y_d  = player_y_q + 1'b1;
        end else if (lf_e) begin
`ifdef WRAP_X_EN
            mv_ok_d = 1'b1;
            mv_x_d  = (player_x_q == '0) ? COL_W'(GRID_W - 1) : player_x_q - 1'b1;
`else
            mv_ok_d = (player_x_q != '0);
            mv_x_d  = player_x_q - 1'b1;
`endif
        end else if (rt_e) begin
`ifdef WRAP_X_EN
            mv_ok_d = 1'b1;
            mv_x_d  = (player_x_q == COL_W'(GRID_W - 1)) ? '0 : player_x_q + 1'b1;
`else
            mv_ok_d = (player_x_q != COL_W'(GRID_W - 1));
            mv_x_d  = player_x_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            rd_wait_q   <= 1'b0;
            player_x_q  <= COL_W'(START_X);
            player_y_q  <= ROW_W'(START_Y);
            tx_q        <= '0;
            ty_q        <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            wr_tile_q   <= '0;
            wr_valid_q  <= 1'b0;
            under_q     <= TILE_GRASS;
            new_under_q <= '0;
            busy_q      <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            level_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mv_ok_d) begin
                        tx_q      <= mv_x_d;
                        ty_q      <= mv_y_d;
                        rd_row_q  <= mv_y_d;
                        rd_col_q  <= mv_x_d;
                        rd_wait_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_READ;
                    end
                end
                // First READ cycle presents the address; read data is valid on the second.
                ST_READ: begin
                    if (rd_wait_q) begin
                        rd_wait_q <= 1'b0;
                    end else begin
                        new_under_q <= i_Rd_Tile;
                        wr_valid_q  <= 1'b1;
                        wr_row_q    <= player_y_q;
                        wr_col_q    <= player_x_q;
                        wr_tile_q   <= under_q;
                        state_q     <= ST_WR_OLD;
                    end
                end
                ST_WR_OLD: begin
                    if (i_Wr_Ready) begin
                        wr_row_q  <= ty_q;
                        wr_col_q  <= tx_q;
                        wr_tile_q <= TILE_PLAYER;
                        state_q   <= ST_WR_NEW;
                    end
                end
                ST_WR_NEW: begin
                    if (i_Wr_Ready) begin
                        player_x_q <= tx_q;
                        player_y_q <= ty_q;
                        under_q    <= new_under_q;
                        wr_valid_q <= 1'b0;
                        if (ty_q == '0) begin
                            level_q  <= 1'b1;
                            tx_q     <= COL_W'(START_X);
                            ty_q     <= ROW_W'(START_Y);
                            rd_row_q <= ROW_W'(START_Y);
                            rd_col_q <= COL_W'(START_X);
                            state_q  <= ST_RESPAWN;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                // Spawn address is already on the bus, so this stands in for the READ wait cycle.
                ST_RESPAWN: begin
                    rd_wait_q <= 1'b0;
                    state_q   <= ST_READ;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Rd_Row   = rd_row_q;
    assign o_Rd_Col   = rd_col_q;
    assign o_Wr_Valid = wr_valid_q;
    assign o_Wr_Row   = wr_row_q;
    assign o_Wr_Col   = wr_col_q;
    assign o_Wr_Tile  = wr_tile_q;
    assign o_Player_X = player_x_q;
    assign o_Player_Y = player_y_q;
    assign o_Busy     = busy_q;
    assign o_Level_Up = level_q;

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Upstream stage of the VGA tile renderer: turns the four board switches into player moves on the 20x15 game map.
- Debounces and edge-detects the switches, bounds-checks the move, then edits the shared tile map over a read/write port.
- Restores the tile the player was standing on and stamps the player tile at the new cell.
- Emits a one-cycle level-up pulse when the player reaches row 0, then respawns the player.

Parameters:
- GRID_W, 20, map columns
- GRID_H, 15, map rows
- START_X, 10, spawn column
- START_Y, 14, spawn row
- DEBOUNCE_CYCLES, 250000, stable cycles required before a switch change is accepted (10 ms at 25 MHz)

Ports:
- i_Clk  in  1  system clock, 25 MHz
- i_Reset  in  1  asynchronous, active-high reset
- i_Switch_1  in  1  up (raw, asynchronous)
- i_Switch_2  in  1  down
- i_Switch_3  in  1  left
- i_Switch_4  in  1  right
- o_Rd_Row  out  4  map read row
- o_Rd_Col  out  5  map read column
- i_Rd_Tile  in  3  tile at the read address, valid exactly 1 cycle after the address
- o_Wr_Valid  out  1  map write request
- o_Wr_Row  out  4  write row
- o_Wr_Col  out  5  write column
- o_Wr_Tile  out  3  tile code to write
- i_Wr_Ready  in  1  map accepts the write on a cycle where Valid and Ready are both high
- o_Player_X  out  5  current column
- o_Player_Y  out  4  current row
- o_Busy  out  1  high whenever the FSM is not in IDLE
- o_Level_Up  out  1  one-cycle pulse

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; o_Player_X=START_X, o_Player_Y=START_Y.
  - Saved under-tile=TILE_GRASS (001).
  - o_Wr_Valid=0, o_Level_Up=0, o_Busy=0; Rd/Wr addresses=0, o_Wr_Tile=0.
  - Debounce counters and debounced levels cleared to 0.
  - Reset mid-transaction abandons it; the map is not repaired.
- Input conditioning, per switch:
  - 2-flop synchronizer, then debounce: the debounced level changes only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Move request = 1-cycle rising edge of the debounced level.
- Arbitration in IDLE:
  - Priority up > down > left > right; lower-priority edges in the same cycle are dropped.
  - Edges arriving while not IDLE are dropped, not queued.
- Bounds:
  - up at Y=0, down at Y=GRID_H-1, left at X=0, right at X=GRID_W-1: move ignored, FSM stays IDLE, no map traffic.
- FSM states:
  - IDLE: on an accepted move, latch target (tx,ty), drive o_Rd_Row/Col=(ty,tx), go to READ.
  - READ: one wait cycle; capture i_Rd_Tile into new_under; go to WR_OLD.
  - WR_OLD: Valid=1, address=current position, tile=saved under-tile. Hold all Wr signals stable until Ready. On the handshake go to WR_NEW.
  - WR_NEW: Valid=1, address=(ty,tx), tile=TILE_PLAYER (010). On the handshake:
    - update position to (tx,ty); saved under-tile <= new_under;
    - if ty==0: pulse o_Level_Up the next cycle, set target=(START_X,START_Y), go to READ via RESPAWN;
    - otherwise go to IDLE.
  - RESPAWN: drive the read address to the spawn cell for one cycle, then proceed as READ.
- Latency: a move with Ready tied high takes 4 cycles from the accepted edge to IDLE, and o_Player_X/Y update on the WR_NEW handshake edge.
- Reads of the player's own cell never occur; the target always differs from the current position, except a spawn-cell collision, which is treated normally.
- Widths: coordinate arithmetic is unsigned at the port widths. No overflow is possible after the bounds check.

Optional Feature:
- Macro: WRAP_X_EN.
- Defined: left at X=0 targets X=GRID_W-1, and right at X=GRID_W-1 targets X=0. These follow the normal read/write sequence.
- Undefined: both are ignored, per Bounds. Vertical moves never wrap in either case.

Decomposition:
- Shared package game_pkg:
  - tile codes TILE_ROAD=000, TILE_GRASS=001, TILE_PLAYER=010;
  - GRID_W/GRID_H defaults and coordinate widths;
  - FSM state encoding.
  - The renderer and map RAM use the same package.
- Sub-module switch_debounce (synchronizer + counter + rising-edge output), instantiated four times.

Test Plan (DEBOUNCE_CYCLES=4, i_Wr_Ready=1 unless stated):
- Reset, then Switch_1 held 6 cycles -> reads (13,10); writes (14,10)=001 then (13,10)=010; Player=(10,13); Busy high exactly 4 cycles.
- Switch_1 glitch of 2 cycles -> no edge, no map traffic, Player stays (10,14).
- Player at X=0, Switch_3 pressed -> without WRAP_X_EN no traffic and X=0; with WRAP_X_EN writes (ty,0)=under-tile, then (ty,19)=010, X=19.
- i_Wr_Ready low for 5 cycles during WR_OLD -> Valid/Row/Col/Tile held constant; sequence completes after Ready rises; Switch_2 edge during busy ignored.
- Player at (10,1), Switch_1 -> writes (0,10)=010; o_Level_Up pulses 1 cycle; respawn writes (0,10)=under, (14,10)=010; Player=(10,14).
- Switch_1 and Switch_4 rising in the same cycle -> only the up move executes.
